// File: rtl/spi_transaction_sequencer.sv
// Command FIFO plus launch FSM driving a half-duplex SPI core and returning read data or a timeout.
// Latency: command accepted at edge N -> spi_start high after edge N+2; next launch GAP_CYCLES+2 edges after spi_done.
// Backpressure: cmd_ready drops when the FIFO is full; a held response (rsp_valid) blocks further launches.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         fabric_clk,
  input  logic         reset_n,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign wr_en  = wr_vld && !full;
  assign rd_en  = rd_vld && !empty;
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge fabric_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

module spi_transaction_sequencer #(
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 8,
  parameter int FIFO_DEPTH            = 8,
  parameter int GAP_CYCLES            = 4,
  parameter int TIMEOUT_CYCLES        = 4096
) (
  input  logic                             fabric_clk,
  input  logic                             reset_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [TRANSACTION_LEN_WIDTH-1:0] cmd_length,
  input  logic [DATA_WIDTH-1:0]            cmd_data,
  input  logic [DATA_WIDTH-1:0]            cmd_rw_mask,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_timeout,
  output logic [TRANSACTION_LEN_WIDTH-1:0] transaction_length,
  output logic [DATA_WIDTH-1:0]            transaction_data,
  output logic [DATA_WIDTH-1:0]            transaction_rw_mask,
  input  logic [DATA_WIDTH-1:0]            transaction_read_data,
  output logic                             spi_start,
  input  logic                             spi_done,
  output logic                             busy,
  output logic [7:0]                       err_len_count
);
  localparam int TLW  = TRANSACTION_LEN_WIDTH;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GP_W-1:0] GAP_LAST = GP_W'(GAP_CYCLES - 1);
  localparam logic [TLW:0]    MAX_LEN  = (TLW + 1)'(DATA_WIDTH);

  typedef struct packed {
    logic [TLW-1:0]        len;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] mask;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t          state;
  cmd_t            fifo_wr_dat;
  cmd_t            fifo_rd_dat;
  logic            fifo_wr_vld;
  logic            fifo_rd_vld;
  logic            fifo_full;
  logic            fifo_empty;
  logic            cmd_acc;
  logic            len_ok;
  logic [TO_W-1:0] to_cnt;
  logic [GP_W-1:0] gap_cnt;

  assign cmd_ready   = !fifo_full;
  assign cmd_acc     = cmd_valid && cmd_ready;
  assign len_ok      = (cmd_length != '0) && ({1'b0, cmd_length} <= MAX_LEN);
  // Illegal lengths still complete the handshake; they are counted, never stored.
  assign fifo_wr_vld = cmd_acc && len_ok;
  assign fifo_wr_dat = '{len: cmd_length, data: cmd_data, mask: cmd_rw_mask};
  assign fifo_rd_vld = (state == S_IDLE) && !fifo_empty && !rsp_valid;
  assign busy        = (state != S_IDLE) || !fifo_empty;

  sync_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .fabric_clk (fabric_clk),
    .reset_n    (reset_n),
    .wr_vld     (fifo_wr_vld),
    .wr_dat     (fifo_wr_dat),
    .rd_vld     (fifo_rd_vld),
    .rd_dat     (fifo_rd_dat),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      err_len_count <= 8'd0;
    end else if (cmd_acc && !len_ok && (err_len_count != 8'hFF)) begin
      err_len_count <= err_len_count + 8'd1;
    end
  end

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      spi_start           <= 1'b0;
      transaction_length  <= '0;
      transaction_data    <= '0;
      transaction_rw_mask <= '0;
      rsp_valid           <= 1'b0;
      rsp_data            <= '0;
      rsp_timeout         <= 1'b0;
      to_cnt              <= '0;
      gap_cnt             <= '0;
    end else begin
      spi_start <= 1'b0;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (fifo_rd_vld) begin
            transaction_length  <= fifo_rd_dat.len;
            transaction_data    <= fifo_rd_dat.data;
            transaction_rw_mask <= fifo_rd_dat.mask;
            state               <= S_START;
          end
        end

        S_START: begin
          spi_start <= 1'b1;
          to_cnt    <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          // A done pulse arriving on the final timeout cycle still counts as a normal completion.
          if (spi_done) begin
            rsp_data    <= transaction_read_data;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            gap_cnt     <= '0;
            state       <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else if ((TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST)) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            gap_cnt     <= '0;
            state       <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Directed bench for spi_transaction_sequencer with a behavioural SPI core model.
// Timeout is 24 so the 20-cycle transaction completes while the never-responding one expires.
module tb_spi_transaction_sequencer;
  localparam int DW    = 32;
  localparam int TLW   = 8;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int TO    = 24;
  localparam logic [31:0] K     = 32'hA5A5_1234;
  localparam logic [31:0] MAGIC = 32'hDEAD_DEAD;

  typedef struct packed {
    logic [TLW-1:0] len;
    logic [DW-1:0]  data;
    logic [DW-1:0]  mask;
  } cmd_t;

  logic           fabric_clk;
  logic           reset_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [TLW-1:0] cmd_length;
  logic [DW-1:0]  cmd_data;
  logic [DW-1:0]  cmd_rw_mask;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [DW-1:0]  rsp_data;
  logic           rsp_timeout;
  logic [TLW-1:0] transaction_length;
  logic [DW-1:0]  transaction_data;
  logic [DW-1:0]  transaction_rw_mask;
  logic [DW-1:0]  transaction_read_data;
  logic           spi_start;
  logic           spi_done;
  logic           busy;
  logic [7:0]     err_len_count;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int n_start = 0;
  int last_start_edge = 0;
  int done_edge = 0;
  int push_edge = 0;
  int core_cnt = 0;
  int core_delay = 20;
  logic core_hold = 1'b0;
  logic chk_gap = 1'b0;
  logic have_done = 1'b0;
  logic in_txn = 1'b0;
  logic unstable = 1'b0;
  logic prev_start = 1'b0;
  logic [DW-1:0] core_rdata = '0;
  cmd_t cur_cmd;
  cmd_t exp_cmd_q[$];
  logic [DW:0] exp_rsp_q[$];
  logic [DW:0] rsp_q[$];

  spi_transaction_sequencer #(
    .DATA_WIDTH            (DW),
    .TRANSACTION_LEN_WIDTH (TLW),
    .FIFO_DEPTH            (DEPTH),
    .GAP_CYCLES            (GAP),
    .TIMEOUT_CYCLES        (TO)
  ) dut (
    .fabric_clk            (fabric_clk),
    .reset_n               (reset_n),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_length            (cmd_length),
    .cmd_data              (cmd_data),
    .cmd_rw_mask           (cmd_rw_mask),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_data              (rsp_data),
    .rsp_timeout           (rsp_timeout),
    .transaction_length    (transaction_length),
    .transaction_data      (transaction_data),
    .transaction_rw_mask   (transaction_rw_mask),
    .transaction_read_data (transaction_read_data),
    .spi_start             (spi_start),
    .spi_done              (spi_done),
    .busy                  (busy),
    .err_len_count         (err_len_count)
  );

  initial begin
    fabric_clk = 1'b0;
    forever #5 fabric_clk = ~fabric_clk;
  end

  initial forever begin
    @(posedge fabric_clk);
    edge_cnt++;
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fabric_clk);
    #1;
  endtask

  // Core model and monitor: sampled mid-cycle, drives spi_done D negedges after seeing spi_start.
  initial begin
    spi_done = 1'b0;
    transaction_read_data = '0;
    forever begin
      @(negedge fabric_clk);
      if (!reset_n) begin
        core_cnt = 0;
        in_txn = 1'b0;
        prev_start = 1'b0;
        spi_done = 1'b0;
      end else begin
        if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_timeout, rsp_data});
        if (in_txn) begin
          if ({transaction_length, transaction_data, transaction_rw_mask} != cur_cmd) unstable = 1'b1;
          if (rsp_valid) begin
            chk("txn_stable", unstable, 0);
            in_txn = 1'b0;
          end
        end
        spi_done = 1'b0;
        if (core_cnt > 0 && !core_hold) begin
          core_cnt--;
          if (core_cnt == 0) begin
            spi_done = 1'b1;
            transaction_read_data = core_rdata;
            done_edge = edge_cnt + 1;
            have_done = 1'b1;
          end
        end
        if (spi_start) begin
          chk("start_pulse_width", prev_start, 0);
          n_start++;
          last_start_edge = edge_cnt;
          if (chk_gap && have_done) chk("done_to_start_edges", edge_cnt - done_edge, GAP + 2);
          chk("start_has_cmd", exp_cmd_q.size() != 0, 1);
          if (exp_cmd_q.size() != 0) begin
            cmd_t e;
            e = exp_cmd_q.pop_front();
            chk("start_len", transaction_length, e.len);
            chk("start_data", transaction_data, e.data);
            chk("start_mask", transaction_rw_mask, e.mask);
          end
          cur_cmd = {transaction_length, transaction_data, transaction_rw_mask};
          unstable = 1'b0;
          in_txn = 1'b1;
          if (transaction_data != MAGIC) begin
            core_cnt = core_delay;
            core_rdata = transaction_data ^ K;
          end
        end
        prev_start = spi_start;
      end
    end
  end

  task automatic push_cmd(input logic [TLW-1:0] len, input logic [DW-1:0] data, input logic [DW-1:0] mask);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_length = len;
    cmd_data = data;
    cmd_rw_mask = mask;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    push_edge = edge_cnt;
    chk("cmd_accepted", acc, 1);
    if (len != 0 && len <= DW) begin
      exp_cmd_q.push_back('{len: len, data: data, mask: mask});
      exp_rsp_q.push_back((data == MAGIC) ? {1'b1, 32'h0} : {1'b0, data ^ K});
    end
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && rsp_q.size() < n; i++) tick();
    chk(tag, rsp_q.size() >= n, 1);
  endtask

  task automatic drain(input string tag);
    logic [DW:0] got;
    while (rsp_q.size() != 0) begin
      got = rsp_q.pop_front();
      chk("rsp_expected", exp_rsp_q.size() != 0, 1);
      if (exp_rsp_q.size() != 0) chk(tag, got, exp_rsp_q.pop_front());
    end
    chk("rsp_missing", exp_rsp_q.size(), 0);
  endtask

  initial begin
    int n0;
    int rsp_edge;
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_length = '0;
    cmd_data = '0;
    cmd_rw_mask = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_err_len", err_len_count, 0);
    chk("rst_rsp_data", {rsp_timeout, rsp_data}, 0);
    chk("rst_txn", {transaction_length, transaction_data, transaction_rw_mask}, 0);
    reset_n = 1'b1;
    tick();

    // Single command, 20-cycle core
    rsp_ready = 1'b1;
    core_delay = 20;
    n0 = n_start;
    push_cmd(8'd16, 32'hA5A5_0000, 32'hFF00_0000);
    wait_rsp("t1_rsp_arrived", 1, 100);
    chk("t1_latency", last_start_edge - push_edge, 2);
    chk("t1_starts", n_start - n0, 1);
    chk("t1_rsp", rsp_q[0], {1'b0, 32'h0000_1234});
    drain("t1_rsp_order");

    // Illegal lengths are swallowed and counted
    n0 = n_start;
    push_cmd(8'd0, 32'h1111_1111, 32'hFFFF_FFFF);
    push_cmd(8'd33, 32'h2222_2222, 32'hFFFF_FFFF);
    repeat (20) tick();
    chk("t4_err_len", err_len_count, 2);
    chk("t4_starts", n_start - n0, 0);
    chk("t4_no_rsp", rsp_q.size(), 0);
    chk("t4_busy", busy, 0);

    // Nine commands with the core stalled, then back-to-back drain
    core_delay = 5;
    core_hold = 1'b1;
    have_done = 1'b0;
    chk_gap = 1'b1;
    for (int i = 0; i < 9; i++)
      push_cmd(TLW'(i + 1), 32'h1000_0000 + 32'(i * 32'h0101), 32'(32'h8000_0000 >> i));
    chk("t2_full", cmd_ready, 0);
    chk("t2_busy", busy, 1);
    core_hold = 1'b0;
    wait_rsp("t2_rsp_arrived", 9, 400);
    drain("t2_rsp_order");
    chk_gap = 1'b0;
    chk("t2_ready_again", cmd_ready, 1);

    // Held response blocks further launches
    rsp_ready = 1'b0;
    core_delay = 3;
    n0 = n_start;
    push_cmd(8'd32, 32'hCAFE_0001, 32'h0000_FFFF);
    push_cmd(8'd32, 32'hCAFE_0002, 32'h0000_FFFF);
    push_cmd(8'd32, 32'hCAFE_0003, 32'h0000_FFFF);
    for (int i = 0; i < 100 && !rsp_valid; i++) tick();
    repeat (30) tick();
    chk("t3_one_start", n_start - n0, 1);
    chk("t3_rsp_held", rsp_valid, 1);
    chk("t3_rsp_data", {rsp_timeout, rsp_data}, {1'b0, 32'hCAFE_0001 ^ K});
    rsp_ready = 1'b1;
    wait_rsp("t3_rsp_arrived", 3, 200);
    chk("t3_all_starts", n_start - n0, 3);
    drain("t3_rsp_order");

    // Core never answers the first command: timeout, then the next proceeds
    core_delay = 4;
    push_cmd(8'd8, MAGIC, 32'h0);
    push_cmd(8'd12, 32'h0BAD_F00D, 32'hFFF0_0000);
    for (int i = 0; i < 100 && !rsp_valid; i++) tick();
    rsp_edge = edge_cnt;
    chk("t5_timeout_cycles", rsp_edge - last_start_edge, TO);
    chk("t5_rsp_timeout", rsp_timeout, 1);
    chk("t5_rsp_data_zero", rsp_data, 0);
    wait_rsp("t5_rsp_arrived", 2, 200);
    drain("t5_rsp_order");

    // Reset during WAIT with commands queued
    push_cmd(8'd4, MAGIC, 32'h0);
    push_cmd(8'd4, MAGIC, 32'h0);
    push_cmd(8'd4, MAGIC, 32'h0);
    repeat (5) tick();
    chk("t6_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_spi_start", spi_start, 0);
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    n0 = n_start;
    tick();
    reset_n = 1'b1;
    repeat (60) tick();
    chk("t6_no_rsp", rsp_q.size(), 0);
    chk("t6_no_start", n_start - n0, 0);
    chk("t6_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
